keyboard_event_queue: RTL
=========================

// Module: keyboard_event_queue
// PURPOSE
//  Parametrised successor to the single-key keyboard front end. Sits between ps2_keyboard and the CPU/terminal bus.
//  Consumes the raw PS/2 byte stream and decodes make/break/E0 prefixes. Tracks every key's up/down state.
//  Queues complete key events, tagged with a modifier snapshot, in a DEPTH-entry FIFO, so no keystroke is lost to a slow consumer.
// PARAMETERS
//  DEPTH   16  FIFO entries; power of two, >=2
//  CNT_W   $clog2(DEPTH)+1  width of evt_count (derived; do not override)
// PORTS
//  clk            in   1      system clock; all logic on posedge clk
//  rst            in   1      synchronous, active-high reset
//  ps2_data       in   8      byte from ps2_keyboard.data
//  ps2_ready      in   1      ps2_keyboard.ready (byte available)
//  ps2_nextdata_n out  1      to ps2_keyboard.nextdata_n; 1-cycle low pulse per consumed byte
//  evt_valid      out  1      FIFO non-empty
//  evt_data       out  16     head event: [15]brk [14]ext [13]rpt [12]caps [11]alt [10]ctrl [9]shift [8]lost [7:0]scancode
//  evt_ready      in   1      consumer pops head when evt_valid&&evt_ready
//  evt_count      out  CNT_W  entries held, 0..DEPTH
//  overflow       out  1      sticky: an event was dropped on full
//  ovf_clear      in   1      clears overflow (set wins if same cycle)
//  any_key_down   out  1      OR of both key-state tables
// BEHAVIOUR
//  Reset values: ps2_nextdata_n=1. evt_valid=0. evt_count=0. overflow=0. any_key_down=0.
//   Key tables, capslock, lost_pending, FIFO pointers and decoder all clear. evt_data=don't-care while !evt_valid.
//  Byte accept: at edge T, when ps2_ready=1 and ps2_nextdata_n=1.
//   ps2_nextdata_n=0 during T+1 only, back to 1 at T+2. No byte is accepted while it is 0.
//  Decoder FSM: IDLE, E0, F0, E0F0, SKIP.
//   IDLE: E0->E0; F0->F0; E1->SKIP, skip_cnt=7; other->key(ext=0,brk=0)
//   E0: F0->E0F0; E0->E0; other->key(ext=1,brk=0), ->IDLE
//   F0: ->key(ext=0,brk=1), ->IDLE.  E0F0: ->key(ext=1,brk=1), ->IDLE
//   SKIP: discard; skip_cnt-1; ->IDLE when it reaches 0 (Pause sequence, 8 bytes total)
//   Non-key bytes in IDLE produce no event, state unchanged: 00, AA, EE, FA, FC, FE, FF.
//  Key event at accept edge T:
//   down tables: down[code] (ext=0) or down_e0[code] (ext=1); set on make, clear on break.
//   rpt=1 iff make and the key is already down.
//   Modifier snapshot = registered state BEFORE this event's table update:
//    shift = down[12] | down[59]
//    ctrl  = down[14] | down_e0[14]
//    alt   = down[11] | down_e0[11]
//    caps  = capslock flag
//   capslock toggles on non-repeat make of 58 (ext=0). Visible from T+1.
//  FIFO: push at T; evt_valid=1 from T+1 if it was empty.
//   Fall-through head: evt_data = mem[rd_ptr], combinational from the registered array.
//   Push and pop in the same cycle: both take effect, count unchanged. Allowed when full (pop frees the slot).
//   Push when full with no pop: event dropped, overflow<=1, lost_pending<=1.
//   Next accepted push has lost=1, then lost_pending<=0.
//   Pop when empty: ignored.
//   Pointers are CNT_W bits and wrap modulo 2*DEPTH. full = MSBs differ, rest equal.
//  rst mid-sequence (e.g. after E0): decoder->IDLE. Partially received prefixes are discarded.
// CONFIGURATION
//  KBD_REPEAT_FILTER_EN defined: typematic repeat makes (rpt=1) update nothing and are NOT pushed, so bit 13 is always 0.
//   Capslock does not toggle on a repeat.
//  Not defined: repeats are pushed with rpt=1 and the modifier snapshot.
// TESTING
//  1) Bytes 1C, F0 1C -> two events: 0x001C, then 0x801C. evt_count=2. any_key_down 1 then 0.
//  2) 12, 1C, F0 1C, F0 12 -> events 0x0012, 0x021C, 0x821C, 0x8212. Snapshot is pre-update: shift=0 on the 0x12 make, shift=1 on its break.
//  3) E0 75, E0 F0 75 -> 0x4075, 0xC075. Then E1 14 77 E1 F0 14 F0 77 -> no events, FSM back in IDLE.
//  4) DEPTH=4, evt_ready=0, 6 makes -> count=4, overflow=1, 2 dropped. Pop one, push -> new entry has bit 8 set. ovf_clear -> overflow=0.
//  5) 58 (make) -> caps=1 on the next event. Without the macro, 1C 1C -> second event 0x201C|caps. With KBD_REPEAT_FILTER_EN -> one event only.
//  6) Full FIFO, simultaneous pop+push -> count stays DEPTH, no overflow. rst after E0 then 1C -> event 0x001C (ext=0).

Source files
------------

// File: rtl/keyboard_event_queue.sv
`default_nettype none
// ============================================================================
// Module      : keyboard_event_queue
// Description : PS/2 byte-stream decoder (make/break/E0/E1 prefixes) with
//               per-key up/down tables, modifier snapshot and a DEPTH-entry
//               fall-through event FIFO with sticky overflow and lost flag.
//               Optional macro KBD_REPEAT_FILTER_EN suppresses typematic
//               repeat makes entirely.
// Revision    : 1.0 - initial release
// ============================================================================
module keyboard_event_queue #(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       ps2_data,
    input  logic             ps2_ready,
    output logic             ps2_nextdata_n,
    output logic             evt_valid,
    output logic [15:0]      evt_data,
    input  logic             evt_ready,
    output logic [CNT_W-1:0] evt_count,
    output logic             overflow,
    input  logic             ovf_clear,
    output logic             any_key_down
);

    // Pointer MSB position; the bits below it address the storage array.
    localparam int c_AW = CNT_W - 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_E0   = 3'd1,
        S_F0   = 3'd2,
        S_E0F0 = 3'd3,
        S_SKIP = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_skip_cnt;
    logic [2:0]       w_skip_nxt;

    logic             r_nextdata_n;
    logic             w_accept;
    logic             w_key;
    logic             w_ext;
    logic             w_brk;
    logic             w_already;
    logic             w_rpt;
    logic             w_evt;

    logic [255:0]     r_down;
    logic [255:0]     r_down_e0;
    logic             r_caps;
    logic             r_lost_pending;
    logic             r_overflow;

    logic [15:0]      r_mem [DEPTH];
    logic [CNT_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_rd_ptr;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push_ok;
    logic             w_drop;
    logic             w_shift;
    logic             w_ctrl;
    logic             w_alt;
    logic [15:0]      w_evt_word;

    // A byte is taken only while the handshake line is idle-high.
    assign w_accept       = ps2_ready & r_nextdata_n;
    assign ps2_nextdata_n = r_nextdata_n;

    // Handshake: one-cycle low pulse on the cycle after each accepted byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nextdata_n <= 1'b1;
        end else begin
            r_nextdata_n <= ~w_accept;
        end
    end

    // Decoder state register and Pause-sequence skip counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_skip_cnt <= 3'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_skip_cnt <= w_skip_nxt;
        end
    end

    // Decoder next state and key-event decode for the byte being accepted.
    always_comb begin
        w_state_nxt = r_state;
        w_skip_nxt  = r_skip_cnt;
        w_key       = 1'b0;
        w_ext       = 1'b0;
        w_brk       = 1'b0;
        if (w_accept) begin
            case (r_state)
                S_IDLE: begin
                    case (ps2_data)
                        8'hE0: w_state_nxt = S_E0;
                        8'hF0: w_state_nxt = S_F0;
                        8'hE1: begin
                            w_state_nxt = S_SKIP;
                            w_skip_nxt  = 3'd7;
                        end
                        // Controller/ack/self-test bytes carry no key.
                        8'h00, 8'hAA, 8'hEE, 8'hFA,
                        8'hFC, 8'hFE, 8'hFF: w_state_nxt = S_IDLE;
                        default: w_key = 1'b1;
                    endcase
                end
                S_E0: begin
                    if (ps2_data == 8'hF0) begin
                        w_state_nxt = S_E0F0;
                    end else if (ps2_data == 8'hE0) begin
                        w_state_nxt = S_E0;
                    end else begin
                        w_key       = 1'b1;
                        w_ext       = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                S_F0: begin
                    w_key       = 1'b1;
                    w_brk       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                S_E0F0: begin
                    w_key       = 1'b1;
                    w_ext       = 1'b1;
                    w_brk       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                S_SKIP: begin
                    w_skip_nxt = r_skip_cnt - 3'd1;
                    if (r_skip_cnt == 3'd1) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign w_already = w_ext ? r_down_e0[ps2_data] : r_down[ps2_data];
    assign w_rpt     = w_key & ~w_brk & w_already;

`ifdef KBD_REPEAT_FILTER_EN
    assign w_evt = w_key & ~w_rpt;
`else
    assign w_evt = w_key;
`endif

    // Snapshot taken from the tables as they stood before this event.
    assign w_shift = r_down[8'h12] | r_down[8'h59];
    assign w_ctrl  = r_down[8'h14] | r_down_e0[8'h14];
    assign w_alt   = r_down[8'h11] | r_down_e0[8'h11];

    assign w_evt_word = {w_brk, w_ext, w_rpt, r_caps, w_alt, w_ctrl, w_shift,
                         r_lost_pending, ps2_data};

    // Key up/down tables and capslock latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_down    <= '0;
            r_down_e0 <= '0;
            r_caps    <= 1'b0;
        end else if (w_evt) begin
            if (w_ext) begin
                r_down_e0[ps2_data] <= ~w_brk;
            end else begin
                r_down[ps2_data] <= ~w_brk;
            end
            if (!w_brk && !w_ext && !w_rpt && ps2_data == 8'h58) begin
                r_caps <= ~r_caps;
            end
        end
    end

    assign any_key_down = (|r_down) | (|r_down_e0);

    // FIFO status; pointers carry an extra wrap bit to tell full from empty.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_pop     = evt_ready & ~w_empty;
    assign w_push_ok = w_evt & (~w_full | w_pop);
    assign w_drop    = w_evt & w_full & ~w_pop;

    // Event storage; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= w_evt_word;
        end
    end

    // FIFO pointers, sticky overflow and lost-event marker.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_overflow     <= 1'b0;
            r_lost_pending <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr       <= r_wr_ptr + CNT_W'(1);
                r_lost_pending <= 1'b0;
            end else if (w_drop) begin
                r_lost_pending <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + CNT_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clear) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign evt_valid = ~w_empty;
    assign evt_data  = r_mem[r_rd_ptr[c_AW-1:0]];
    assign evt_count = r_wr_ptr - r_rd_ptr;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire
